// File: rtl/desc_feeder.sv
// desc_feeder: streams one 8x8-pixel patch (8 rows x 2 words) from frame
// memory as 16 descriptor words, one read every (1+GAP) cycles.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle request to stream a patch
//   patch_x, patch_y     patch left edge (words) and top row
//   mem_rd_en, mem_addr  frame-memory read strobe and word address
//   mem_rd_data          read data, valid the cycle after mem_rd_en
//   desc_data_ready      one-cycle strobe, desc_data holds a new word
//   desc_data            4 pixels, leftmost pixel in [31:24]
//   busy, done, err      transfer active / finished pulse / rejected pulse
module desc_feeder #(
  parameter int unsigned IMG_W_WORDS = 160,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned GAP         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        patch_x,
  input  logic [9:0]        patch_y,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              desc_data_ready,
  output logic [31:0]       desc_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PX_W   = 8;
  localparam int unsigned PY_W   = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned GAP_W  = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(15);
  localparam logic [GAP_W-1:0] GAP_CNT   = GAP_W'(GAP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PY_W-1:0]   py_q, py_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              in_bounds_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Word k of the patch: row k[3:1], column k[0]; wraps to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [PY_W-1:0]  y,
                                                  input logic [PX_W-1:0]  x,
                                                  input logic [CNT_W-1:0] k);
    logic [31:0] lin;
    lin = (32'(y) + 32'(k[3:1])) * 32'(IMG_W_WORDS) + 32'(x) + 32'(k[0]);
    return ADDR_W'(lin);
  endfunction

  // Patch must fit entirely inside the frame.
  assign in_bounds_c = (32'(patch_x) <= (IMG_W_WORDS - 32'd2)) &&
                       (32'(patch_y) <= (IMG_H - 32'd8));

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_inc_c = cnt_q + CNT_W'(1);
    // Read-return pipeline: data arrives the cycle after the strobe and is
    // shown (with the ready strobe) the cycle after that.
    vld_d     = rd_en_q;
    rdy_d     = vld_q;
    data_d    = vld_q ? mem_rd_data : data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (in_bounds_c) begin
            // Word 0 is issued straight from the request cycle.
            state_d = S_RUN;
            px_d    = patch_x;
            py_d    = patch_y;
            cnt_d   = '0;
            gap_d   = GAP_CNT;
            rd_en_d = 1'b1;
            addr_d  = word_addr(patch_y, patch_x, CNT_W'(0));
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          cnt_d   = cnt_inc_c;
          gap_d   = GAP_CNT;
          rd_en_d = 1'b1;
          addr_d  = word_addr(py_q, px_q, cnt_inc_c);
          if (cnt_inc_c == LAST_WORD) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Last strobe is the one with no read outstanding behind it.
        if (rdy_q && !vld_q && !rd_en_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = addr_q;
  assign desc_data_ready = rdy_q;
  assign desc_data       = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: doc/desc_feeder.md
DESC_FEEDER -- requirements
Module: desc_feeder

Interface
REQ-001 Parameter IMG_W_WORDS, default 160: image row width in 32-bit words (4 pixels/word).
REQ-002 Parameter IMG_H, default 480: image height in rows.
REQ-003 Parameter ADDR_W, default 17: frame-memory word-address width.
REQ-004 Parameter GAP, default 1: idle cycles between successive desc_data_ready strobes (range 0-7).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to stream one 8x8 patch.
REQ-008 patch_x  input  8  patch left edge, in words.
REQ-009 patch_y  input  10  patch top row.
REQ-010 mem_rd_en  output  1  frame-memory read strobe.
REQ-011 mem_addr  output  ADDR_W  frame-memory word address.
REQ-012 mem_rd_data  input  32  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 desc_data_ready  output  1  one-cycle strobe: desc_data holds a valid descriptor word.
REQ-014 desc_data  output  32  4 pixels; leftmost pixel in [31:24], rightmost in [7:0].
REQ-015 busy  output  1  transfer in progress.
REQ-016 done  output  1  one-cycle pulse after the 16th word.
REQ-017 err  output  1  one-cycle pulse: start rejected, patch out of bounds.

Function
REQ-018 A transfer streams 16 words: rows r=0..7, per row words c=0,1 (row-major, c=0 first).
REQ-019 Word (r,c) address = (patch_y+r)*IMG_W_WORDS + patch_x + c, unsigned, truncated to ADDR_W.
REQ-020 FSM states: IDLE, RUN, DRAIN; rst forces IDLE.
REQ-021 IDLE: start=1 with patch_x <= IMG_W_WORDS-2 and patch_y <= IMG_H-8 latches patch_x/patch_y and enters RUN; busy=1 from the next cycle.
REQ-022 IDLE: start=1 with out-of-bounds coordinates pulses err the next cycle and stays IDLE; no memory reads.
REQ-023 start while busy=1 is ignored; latched coordinates do not change.
REQ-024 Start sampled at cycle t0: word k is read (mem_rd_en=1) at t0+1+k*(1+GAP), with mem_rd_en=0 on all other cycles.
REQ-025 mem_rd_data is registered into desc_data one cycle after the read; desc_data_ready=1 in the cycle desc_data first shows that word, i.e. at t0+3+k*(1+GAP).
REQ-026 desc_data holds its value between strobes; desc_data_ready is never high two consecutive cycles when GAP>=1.
REQ-027 After the 16th read, RUN enters DRAIN; DRAIN waits for the 16th strobe.
REQ-028 done=1 the cycle after the 16th strobe; busy=0 in that same cycle; FSM returns to IDLE.
REQ-029 start may be accepted in the done cycle; the next transfer begins normally.
REQ-030 Word counter 4 bits, row = count[3:1], col = count[0]; no wrap beyond 16 words.

Reset
REQ-031 On rst: state IDLE; busy, done, err, mem_rd_en, desc_data_ready = 0; desc_data = 0; mem_addr = 0; counters = 0.
REQ-032 rst during RUN or DRAIN aborts the transfer next cycle: no further strobes, no done pulse; pending read data is discarded.

Verification
REQ-033 Memory model mem[a]=a, GAP=1, start with patch_x=3, patch_y=5 -> 16 strobes, desc_data = 803, 804, 963, 964, ..., 1923, 1924; first strobe at t0+3, last at t0+33; done at t0+34.
REQ-034 Same, GAP=0 -> 16 strobes on 16 consecutive cycles t0+3..t0+18; done at t0+19.
REQ-035 start with patch_x=159 (IMG_W_WORDS=160) -> err=1 at t0+1, busy=0, no mem_rd_en ever; same for patch_y=473.
REQ-036 Boundary accept patch_x=158, patch_y=472 -> last desc_data = 479*160+159 = 76799; done pulses.
REQ-037 Second start at t0+10 during transfer -> ignored, stream identical to REQ-033; start in done cycle -> new stream's first strobe 3 cycles later.
REQ-038 rst at t0+12 -> from t0+13 all outputs 0, no strobes, no done; subsequent start works normally.
